// File: rtl/ifetch_line_buffer.sv
// ifetch_line_buffer: two-entry instruction line buffer in front of the L1 icache.
// CUR holds the active line; PF holds the sequential successor line.
module ifetch_line_buffer #(
  parameter bit PREFETCH_EN = 1'b1,
  parameter int OFFSET_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  cpu_addr,
  input  logic         cpu_read,
  output logic         cpu_resp,
  output logic [127:0] cpu_rdata,
  input  logic         flush,
  output logic [15:0]  ic_addr,
  output logic         ic_read,
  input  logic         ic_resp,
  input  logic [127:0] ic_rdata
);

  localparam int TW = 16 - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEMAND = 2'd1,
    PREF   = 2'd2
  } state_e;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic [127:0]  data;
  } entry_t;

  state_e        state_q, state_d;
  entry_t        cur_q, cur_d;
  entry_t        pf_q, pf_d;
  logic [15:0]   req_addr_q, req_addr_d;
  logic          req_is_pf_q, req_is_pf_d;
  logic          drop_q, drop_d;

  logic [TW-1:0] cpu_tag;
  logic [TW-1:0] nxt_tag;
  logic          hit_cur;
  logic          hit_pf;
  logic          miss;
  logic          serve_pf;
  logic          busy;
  logic          fill;
  logic          unused_offset;

  assign cpu_tag  = cpu_addr[15:OFFSET_BITS];
  assign nxt_tag  = cur_q.tag + TW'(1);
  assign unused_offset = ^cpu_addr[OFFSET_BITS-1:0];

  assign hit_cur  = cur_q.v && (cur_q.tag == cpu_tag);
  assign hit_pf   = pf_q.v && (pf_q.tag == cpu_tag) && !hit_cur;
  assign miss     = cpu_read && !hit_cur && !hit_pf;
  assign serve_pf = cpu_read && hit_pf && !flush;

  assign cpu_resp  = cpu_read && (hit_cur || hit_pf) && !flush;
  assign cpu_rdata = hit_pf ? pf_q.data : cur_q.data;

  assign busy    = (state_q != IDLE);
  assign fill    = busy && ic_resp && !drop_q && !flush;
  assign ic_read = busy;
  assign ic_addr = req_addr_q;

  // Request sequencing: demand misses first, then sequential prefetch.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_is_pf_d = req_is_pf_q;
    drop_d      = drop_q;
    unique case (state_q)
      IDLE: begin
        if (!flush) begin
          if (miss) begin
            req_addr_d  = {cpu_tag, {OFFSET_BITS{1'b0}}};
            req_is_pf_d = 1'b0;
            state_d     = DEMAND;
          end else if (PREFETCH_EN && cur_q.v && !pf_q.v) begin
            req_addr_d  = {nxt_tag, {OFFSET_BITS{1'b0}}};
            req_is_pf_d = 1'b1;
            state_d     = PREF;
          end
        end
      end
      DEMAND, PREF: begin
        if (ic_resp) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (flush) begin
          drop_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry updates: promote, then fill, with flush overriding both.
  always_comb begin
    cur_d = cur_q;
    pf_d  = pf_q;
    if (serve_pf) begin
      cur_d   = pf_q;
      pf_d.v  = 1'b0;
    end
    if (fill && !req_is_pf_q) begin
      cur_d = {1'b1, req_addr_q[15:OFFSET_BITS], ic_rdata};
    end
    if (fill && req_is_pf_q) begin
      pf_d  = {1'b1, req_addr_q[15:OFFSET_BITS], ic_rdata};
    end
    if (flush) begin
      cur_d.v = 1'b0;
      pf_d.v  = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_is_pf_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_is_pf_q <= req_is_pf_d;
      drop_q      <= drop_d;
    end
  end

  // Line storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      pf_q  <= '0;
    end else begin
      cur_q <= cur_d;
      pf_q  <= pf_d;
    end
  end

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// tb_ifetch_line_buffer: directed plus randomized checks of the line buffer
// against a behavioural model of its hit/fill/prefetch rules.
module tb_ifetch_line_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  cpu_addr;
  logic         cpu_read;
  logic         flush;
  logic         cpu_resp, cpu_resp0;
  logic [127:0] cpu_rdata, cpu_rdata0;
  logic [15:0]  ic_addr, ic_addr0;
  logic         ic_read, ic_read0;
  logic         ic_resp, ic_resp0;
  logic [127:0] ic_rdata, ic_rdata0;

  logic         rq1, rq0, spur;
  int           cnt1, cnt0, lat;
  int           ncmp = 0;
  int           nerr = 0;

  always #5 clk = ~clk;

  assign ic_resp  = rq1 | spur;
  assign ic_resp0 = rq0;

  ifetch_line_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read),
    .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
    .flush(flush),
    .ic_addr(ic_addr), .ic_read(ic_read),
    .ic_resp(ic_resp), .ic_rdata(ic_rdata)
  );

  ifetch_line_buffer #(.PREFETCH_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read),
    .cpu_resp(cpu_resp0), .cpu_rdata(cpu_rdata0),
    .flush(flush),
    .ic_addr(ic_addr0), .ic_read(ic_read0),
    .ic_resp(ic_resp0), .ic_rdata(ic_rdata0)
  );

  function automatic logic [127:0] mem(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'd1,
            a * 16'd3, ~a + 16'd7, a ^ 16'hC3C3, a + 16'h1111};
  endfunction

  // icache model for the prefetching instance
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1 = 1'b0; cnt1 = 0; ic_rdata = '0;
    end else if (rq1) begin
      rq1 = 1'b0; cnt1 = 0;
    end else if (ic_read) begin
      cnt1++;
      if (cnt1 >= lat) begin
        rq1 = 1'b1; ic_rdata = mem(ic_addr);
      end
    end
  end

  // icache model for the demand-only instance
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq0 = 1'b0; cnt0 = 0; ic_rdata0 = '0;
    end else if (rq0) begin
      rq0 = 1'b0; cnt0 = 0;
    end else if (ic_read0) begin
      cnt0++;
      if (cnt0 >= lat) begin
        rq0 = 1'b1; ic_rdata0 = mem(ic_addr0);
      end
    end
  end

  typedef struct packed {
    logic         v;
    logic [11:0]  tag;
    logic [127:0] d;
  } ent_t;

  ent_t        m_cur, m_pf;
  logic        m_busy, m_ispf, m_drop;
  logic [15:0] m_req;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = '0; m_pf = '0;
    m_busy = 1'b0; m_ispf = 1'b0; m_drop = 1'b0; m_req = '0;
  endtask

  // one clock: check outputs against the model, then advance both
  task automatic tick();
    logic [11:0] t;
    logic        hc, hp, er;
    ent_t        nc, np;
    logic        nb, ni, nd;
    logic [15:0] nr;
    #1;
    t  = cpu_addr[15:4];
    hc = m_cur.v && (m_cur.tag == t);
    hp = m_pf.v && (m_pf.tag == t) && !hc;
    er = cpu_read && (hc || hp) && !flush;
    chk("cpu_resp", 128'(cpu_resp), 128'(er));
    chk("cpu_rdata", cpu_rdata, hp ? m_pf.d : m_cur.d);
    chk("ic_read", 128'(ic_read), 128'(m_busy));
    chk("ic_addr", 128'(ic_addr), 128'(m_req));
    nc = m_cur; np = m_pf;
    nb = m_busy; ni = m_ispf; nd = m_drop; nr = m_req;
    if (er && hp) begin
      nc = m_pf; np.v = 1'b0;
    end
    if (m_busy && ic_resp && !m_drop && !flush) begin
      if (m_ispf) np = {1'b1, m_req[15:4], ic_rdata};
      else        nc = {1'b1, m_req[15:4], ic_rdata};
    end
    if (flush) begin
      nc.v = 1'b0; np.v = 1'b0;
    end
    if (m_busy) begin
      if (ic_resp) begin
        nb = 1'b0; nd = 1'b0;
      end else if (flush) begin
        nd = 1'b1;
      end
    end else if (!flush) begin
      if (cpu_read && !hc && !hp) begin
        nb = 1'b1; ni = 1'b0; nr = {t, 4'h0};
      end else if (m_cur.v && !m_pf.v) begin
        nb = 1'b1; ni = 1'b1; nr = {m_cur.tag + 12'd1, 4'h0};
      end
    end
    @(posedge clk);
    m_cur = nc; m_pf = np;
    m_busy = nb; m_ispf = ni; m_drop = nd; m_req = nr;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_resp(input int budget);
    int n = 0;
    while (!ic_resp && n < budget) begin
      tick();
      n++;
    end
    ncmp++;
    assert (ic_resp === 1'b1) else begin
      nerr++;
      $error("FAIL wait_resp: got %b want 1 within %0d cycles", ic_resp, budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cpu_read = 1'b0; flush = 1'b0;
    spur = 1'b0; cpu_addr = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_cpu_resp", 128'(cpu_resp), 128'(0));
    chk("rst_cpu_rdata", cpu_rdata, 128'(0));
    chk("rst_ic_read", 128'(ic_read), 128'(0));
    chk("rst_ic_addr", 128'(ic_addr), 128'(0));
    chk("rst_ic_read0", 128'(ic_read0), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int r;
    lat = 3;
    do_reset();

    // demand miss, then sequential prefetch
    cpu_addr = 16'h0100; cpu_read = 1'b1;
    tick();
    chk("t1_ic_addr", 128'(ic_addr), 128'(16'h0100));
    chk("t1_ic_read", 128'(ic_read), 128'(1));
    wait_resp(10);
    tick();
    chk("t1_resp", 128'(cpu_resp), 128'(1));
    chk("t1_rdata", cpu_rdata, mem(16'h0100));
    tick();
    chk("t1_pf_read", 128'(ic_read), 128'(1));
    chk("t1_pf_addr", 128'(ic_addr), 128'(16'h0110));

    // redirect while prefetch outstanding
    cpu_addr = 16'h2000;
    #1;
    chk("t3_no_resp", 128'(cpu_resp), 128'(0));
    wait_resp(10);
    chk("t3_hold", 128'(ic_addr), 128'(16'h0110));
    tick();
    chk("t3_idle_resp", 128'(cpu_resp), 128'(0));
    tick();
    chk("t3_dem_read", 128'(ic_read), 128'(1));
    chk("t3_dem_addr", 128'(ic_addr), 128'(16'h2000));
    wait_resp(10);
    tick();
    chk("t3_resp", 128'(cpu_resp), 128'(1));
    chk("t3_rdata", cpu_rdata, mem(16'h2000));

    // in-line hits and prefetch promote
    do_reset();
    cpu_addr = 16'h0100; cpu_read = 1'b1;
    tick();
    wait_resp(10);
    tick();
    tick();
    wait_resp(10);
    tick();
    for (int a = 16'h0102; a <= 16'h010E; a += 2) begin
      cpu_addr = 16'(a);
      #1;
      chk("t2_hit", 128'(cpu_resp), 128'(1));
      chk("t2_no_ic", 128'(ic_read), 128'(0));
      tick();
    end
    cpu_addr = 16'h0110;
    #1;
    chk("t2_pf_hit", 128'(cpu_resp), 128'(1));
    chk("t2_pf_data", cpu_rdata, mem(16'h0110));
    tick();
    chk("t2_promoted", cpu_rdata, mem(16'h0110));
    chk("t2_idle", 128'(ic_read), 128'(0));
    tick();
    chk("t2_next_pf", 128'(ic_addr), 128'(16'h0120));
    chk("t2_next_rd", 128'(ic_read), 128'(1));

    // flush mid-demand drops the fill
    do_reset();
    cpu_addr = 16'h0300; cpu_read = 1'b1;
    tick();
    chk("t4_addr", 128'(ic_addr), 128'(16'h0300));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_resp(10);
    tick();
    chk("t4_dropped", 128'(cpu_resp), 128'(0));
    tick();
    chk("t4_reissue", 128'(ic_read), 128'(1));
    chk("t4_re_addr", 128'(ic_addr), 128'(16'h0300));
    wait_resp(10);
    tick();
    chk("t4_resp", 128'(cpu_resp), 128'(1));

    // flush coinciding with ic_resp
    do_reset();
    cpu_addr = 16'h0400; cpu_read = 1'b1;
    tick();
    wait_resp(10);
    tick();
    tick();
    wait_resp(10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cpu_addr = 16'h0410;
    #1;
    chk("t5_pf_gone", 128'(cpu_resp), 128'(0));
    cpu_addr = 16'h0400;
    #1;
    chk("t5_cur_gone", 128'(cpu_resp), 128'(0));
    tick();
    chk("t5_miss", 128'(ic_addr), 128'(16'h0400));
    chk("t5_miss_rd", 128'(ic_read), 128'(1));

    // asynchronous reset mid-transaction
    do_reset();
    cpu_addr = 16'h0500; cpu_read = 1'b1;
    tick();
    chk("ar_busy", 128'(ic_read), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("ar_ic_read", 128'(ic_read), 128'(0));
    chk("ar_ic_addr", 128'(ic_addr), 128'(0));

    // tag wrap and demand-only instance
    do_reset();
    cpu_addr = 16'hFFF0; cpu_read = 1'b1;
    tick();
    chk("t6_addr0", 128'(ic_addr0), 128'(16'hFFF0));
    chk("t6_read0", 128'(ic_read0), 128'(1));
    wait_resp(10);
    tick();
    chk("t6_resp", 128'(cpu_resp), 128'(1));
    chk("t6_resp0", 128'(cpu_resp0), 128'(1));
    chk("t6_rdata0", cpu_rdata0, mem(16'hFFF0));
    tick();
    chk("t6_wrap_rd", 128'(ic_read), 128'(1));
    chk("t6_wrap", 128'(ic_addr), 128'(16'h0000));
    chk("t6_nopf0", 128'(ic_read0), 128'(0));
    repeat (4) begin
      tick();
      chk("t6_idle0", 128'(ic_read0), 128'(0));
    end

    // randomized traffic
    do_reset();
    repeat (2000) begin
      lat = $urandom_range(1, 4);
      cpu_read = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 3);
      if (r == 0) begin
        r = $urandom_range(0, 9);
        if (r < 7)
          cpu_addr = 16'h0100 + 16'($urandom_range(0, 5) * 16)
                   + 16'($urandom_range(0, 15));
        else if (r < 8)
          cpu_addr = 16'hFFF0 | 16'($urandom_range(0, 15));
        else if (r < 9)
          cpu_addr = 16'($urandom_range(0, 15));
        else
          cpu_addr = 16'h2000 | 16'($urandom_range(0, 15));
      end else if (r == 1) begin
        cpu_addr = cpu_addr + 16'd2;
      end
      flush = ($urandom_range(0, 49) == 0);
      spur  = !ic_read && ($urandom_range(0, 19) == 0);
      tick();
    end
    spur = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
